// File: rtl/seq_det_pkg.sv
// ---------------------------------------------------------------------------
// seq_det_pkg
// Shared constants and the elaboration-time transition helper for the serial
// Mealy sequence detector.
//   DEF_PATTERN_W / DEF_PATTERN : default build detects "11".
//   seq_step()                  : for (state k, input bit b) returns
//                                 {match, next_state[2:0]}.
// ---------------------------------------------------------------------------
package seq_det_pkg;

  localparam int         DEF_PATTERN_W = 2;
  localparam logic [7:0] DEF_PATTERN   = 8'b0000_0011;

  // State k means the last k received bits equal the first k bits of the
  // pattern, so the received history is reconstructed from the pattern itself.
  // The next state is the longest pattern prefix (shorter than the full
  // pattern) that is a suffix of history+b; a full match with no overlap
  // restarts from S0.
  function automatic logic [3:0] seq_step(
    input logic [7:0] pattern,
    input int         pw,
    input logic       overlap,
    input int         k,
    input logic       b
  );
    logic [8:0] q;
    int         len;
    int         best;
    logic       match;
    logic       ok;
    q     = 9'b0;
    best  = 0;
    match = 1'b0;
    if (k < pw) begin
      // q[0] is the oldest bit; q[k] is the bit arriving now.
      for (int i = 0; i < 8; i++) begin
        if (i < k) q[i] = pattern[pw-1-i];
      end
      q[k] = b;
      len  = k + 1;

      match = (len == pw);
      for (int t = 0; t < 8; t++) begin
        if (t < len && q[t] != pattern[pw-1-t]) match = 1'b0;
      end

      for (int j = 1; j <= 8; j++) begin
        if (j <= len && j < pw) begin
          ok = 1'b1;
          for (int t = 0; t < 8; t++) begin
            if (t < j && q[len-j+t] != pattern[pw-1-t]) ok = 1'b0;
          end
          if (ok) best = j;
        end
      end

      if (match && !overlap) best = 0;
    end
    return {match, best[2:0]};
  endfunction

endpackage

// File: rtl/seq11_mealy_detector.sv
// ---------------------------------------------------------------------------
// seq11_mealy_detector
// Serial Mealy sequence detector. One bit of `in` is consumed per rising edge
// of `clk`; `out` is raised combinationally in the cycle the final pattern bit
// is present on `in`.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high; forces state to S0 and out to 0
//   in    : serial data bit
//   out   : detect flag, combinational from state register and `in`
// Parameters:
//   PATTERN_W : pattern length, 2..8
//   PATTERN   : target sequence, MSB received first
//   OVERLAP   : 1 lets matched bits seed the next match, 0 restarts at S0
// ---------------------------------------------------------------------------
module seq11_mealy_detector
  import seq_det_pkg::*;
#(
  parameter int                   PATTERN_W = DEF_PATTERN_W,
  parameter logic [PATTERN_W-1:0] PATTERN   = DEF_PATTERN[PATTERN_W-1:0],
  parameter bit                   OVERLAP   = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);

  localparam int         SW   = (PATTERN_W <= 2) ? 1 : $clog2(PATTERN_W);
  localparam int         NS   = 1 << SW;
  localparam logic [7:0] PAT8 = 8'(PATTERN);

  logic [SW-1:0] r_state;
  logic [SW:0]   w_tbl [2*NS];
  logic [SW:0]   w_idx;
  logic [SW:0]   w_entry;
  logic [SW-1:0] w_next;
  logic          w_match;

  // Transition table fixed at elaboration; entry = {match, next_state}.
  // Encodings at or above PATTERN_W are unreachable and fall back to S0.
  for (genvar gk = 0; gk < NS; gk++) begin : g_state
    for (genvar gb = 0; gb < 2; gb++) begin : g_bit
      localparam logic [3:0] E = seq_step(PAT8, PATTERN_W, OVERLAP, gk, 1'(gb));
      assign w_tbl[gk*2+gb] = {E[3], E[SW-1:0]};
    end
  end

  assign w_idx   = {r_state, in};
  assign w_entry = w_tbl[w_idx];
  assign w_next  = w_entry[SW-1:0];
  assign w_match = w_entry[SW];

  // Mealy output: suppressed while reset is asserted.
  assign out = reset ? 1'b0 : w_match;

  // State register with synchronous reset to S0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= '0;
    end else begin
      r_state <= w_next;
    end
  end

endmodule

// File: tb/tb_seq11_mealy_detector.sv
// ---------------------------------------------------------------------------
// tb_seq11_mealy_detector
// Three detector builds share one stimulus stream: default "11" with overlap,
// "11" without overlap, and "101" with overlap.
// ---------------------------------------------------------------------------
module tb_seq11_mealy_detector;

  logic clk;
  logic reset;
  logic din;
  logic out_def;
  logic out_nov;
  logic out_p101;

  int n_chk;
  int n_fail;

  typedef struct {
    logic rst;
    logic din;
    logic e_def;
    logic e_nov;
    logic e_p;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs [NV];
  vec_t sb_q [$];

  seq11_mealy_detector u_def (
    .clk   (clk),
    .reset (reset),
    .in    (din),
    .out   (out_def)
  );

  seq11_mealy_detector #(
    .PATTERN_W (2),
    .PATTERN   (2'b11),
    .OVERLAP   (1'b0)
  ) u_nov (
    .clk   (clk),
    .reset (reset),
    .in    (din),
    .out   (out_nov)
  );

  seq11_mealy_detector #(
    .PATTERN_W (3),
    .PATTERN   (3'b101),
    .OVERLAP   (1'b1)
  ) u_p101 (
    .clk   (clk),
    .reset (reset),
    .in    (din),
    .out   (out_p101)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic d,
                              input logic ed, input logic en, input logic ep);
    vec_t v;
    v.rst   = r;
    v.din   = d;
    v.e_def = ed;
    v.e_nov = en;
    v.e_p   = ep;
    return v;
  endfunction

  task automatic chk(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  initial begin
    vec_t e;
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    din    = 1'b1;

    //           rst   in    def   nov   p101
    vecs[0]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); // reset held, in=1
    vecs[1]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[2]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); // 1,1,1,0 run
    vecs[3]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    vecs[4]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[5]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[6]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1); // alternating 1,0,...
    vecs[7]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[8]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    vecs[9]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[10] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    vecs[11] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[12] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1); // 1, then reset, then 1
    vecs[13] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[14] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[15] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    vecs[16] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[17] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // 101 pattern: 1,0,1,0,1
    vecs[18] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[19] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[20] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    vecs[21] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[22] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    vecs[23] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[24] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); // reset kills "10" prefix
    vecs[25] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[26] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[27] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Table: drive after the edge, push expectation, compare at negedge.
    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      reset = vecs[i].rst;
      din   = vecs[i].din;
      sb_q.push_back(vecs[i]);
      @(negedge clk);
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_empty row %0d: got 0 entries expected 1", i);
      end else begin
        e = sb_q.pop_front();
        chk($sformatf("def_row%0d", i),  out_def,  e.e_def);
        chk($sformatf("nov_row%0d", i),  out_nov,  e.e_nov);
        chk($sformatf("p101_row%0d", i), out_p101, e.e_p);
      end
    end

    // Mid-cycle change of `in` while in S1: out must follow within the cycle.
    @(posedge clk);
    #1;
    din = 1'b0;
    #2;
    chk("mealy_def_lo",  out_def,  1'b0);
    chk("mealy_nov_lo",  out_nov,  1'b0);
    chk("mealy_p101_lo", out_p101, 1'b0);
    din = 1'b1;
    #1;
    chk("mealy_def_hi",  out_def,  1'b1);
    chk("mealy_nov_hi",  out_nov,  1'b1);
    chk("mealy_p101_hi", out_p101, 1'b0);

    // Unknown input under reset: out held low, state must come out clean.
    @(posedge clk);
    #1;
    reset = 1'b1;
    din   = 1'bx;
    #2;
    chk("xrst_def",  out_def,  1'b0);
    chk("xrst_nov",  out_nov,  1'b0);
    chk("xrst_p101", out_p101, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    din   = 1'b0;
    #1;
    chk("xpost_def",  out_def,  1'b0);
    chk("xpost_nov",  out_nov,  1'b0);
    chk("xpost_p101", out_p101, 1'b0);
    @(posedge clk);
    #1;
    din = 1'b1;
    #1;
    chk("xpost1_def", out_def, 1'b0);
    @(posedge clk);
    #1;
    chk("xpost2_def", out_def, 1'b1);
    chk("xpost2_nov", out_nov, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
